mio_bus_ctrl: RTL and testbench

Memory/IO bus controller directly downstream of the multi-cycle CPU controller. It consumes the CPU's MemRead/MemWrite/CPU_MIO request and address/data, and steers each access to block RAM or the on-board peripheral registers. It sequences RAM wait states and returns read data plus a one-cycle MIO_ready pulse, which the CPU controller uses to leave its memory-access states.

---
 rtl/mio_pkg.sv | 36 +++
 rtl/mio_bus_ctrl_if.sv | 28 ++
 rtl/mio_addr_decode.sv | 37 +++
 rtl/mio_bus_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mio_bus_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mio_pkg
// Brief    : Shared types and address map for the memory/IO bus controller.
// Revision : 1.0 - initial release
// ============================================================================
package mio_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RAM_RD = 3'd1,
      ST_RAM_WR = 3'd2,
      ST_IO     = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      RGN_RAM  = 3'd0,
      RGN_GPIO = 3'd1,
      RGN_SW   = 3'd2,
      RGN_CNT  = 3'd3,
      RGN_NONE = 3'd4
   } region_e;

   localparam logic [31:0] GPIO_ADDR = 32'hE000_0000;
   localparam logic [31:0] SW_ADDR   = 32'hF000_0000;
   localparam logic [31:0] CNT_ADDR  = 32'hF000_0004;
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   // Byte lanes are not decoded; every register is a full 32-bit word.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & WORD_MASK;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mio_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mio_bus_ctrl_if
// Brief    : CPU-side request/response bus between CPU controller and MIO.
// Revision : 1.0 - initial release
// ============================================================================
interface mio_bus_ctrl_if;

   logic        CPU_MIO;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] addr_bus;
   logic [31:0] Data_write;
   logic [31:0] Data_read;
   logic        MIO_ready;

   modport master (
      output CPU_MIO, MemRead, MemWrite, addr_bus, Data_write,
      input  Data_read, MIO_ready
   );

   modport slave (
      input  CPU_MIO, MemRead, MemWrite, addr_bus, Data_write,
      output Data_read, MIO_ready
   );

endinterface
`default_nettype wire

// File: rtl/mio_addr_decode.sv
`default_nettype none
// ============================================================================
// Module   : mio_addr_decode
// Brief    : Combinational byte address -> region decode.
//            Counter region exists only when MIO_COUNTER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mio_addr_decode
   import mio_pkg::*;
#(
   parameter logic [31:0] RAM_TOP = 32'h0000_3FFF
) (
   input  logic [31:0] addr,
   output region_e     region
);

   logic [31:0] w_word;

   assign w_word = word_align(addr);

   always_comb begin
      region = RGN_NONE;
      if (w_word <= RAM_TOP) begin
         region = RGN_RAM;
      end else if (w_word == GPIO_ADDR) begin
         region = RGN_GPIO;
      end else if (w_word == SW_ADDR) begin
         region = RGN_SW;
`ifdef MIO_COUNTER_EN
      end else if (w_word == CNT_ADDR) begin
         region = RGN_CNT;
`endif
      end
   end

endmodule
`default_nettype wire

// File: rtl/mio_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mio_bus_ctrl
// Brief    : Steers CPU memory requests to block RAM or peripheral registers,
//            sequences RAM wait states and returns a one-cycle MIO_ready.
//            Optional free-running counter at CNT_ADDR: MIO_COUNTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mio_bus_ctrl
   import mio_pkg::*;
#(
   parameter int          RAM_AW  = 10,
   parameter int          RAM_LAT = 2,
   parameter logic [31:0] RAM_TOP = 32'h0000_3FFF
) (
   input  logic              clk,
   input  logic              reset,
   mio_bus_ctrl_if.slave     bus,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_din,
   output logic              ram_we,
   input  logic [31:0]       ram_dout,
   input  logic [15:0]       sw_in,
   output logic [31:0]       gpio_out,
   output logic              bus_err
);

   localparam logic [2:0] c_wait_last = 3'(RAM_LAT - 1);

   state_e            r_state;
   state_e            w_state_nxt;
   region_e           w_region;
   region_e           r_region;
   logic              w_req;
   logic              w_accept;
   logic              w_ready;
   logic              w_ram_we;
   logic              r_is_write;
   logic [2:0]        r_wait;
   logic [RAM_AW-1:0] r_ram_addr;
   logic [31:0]       r_din;
   logic [31:0]       r_data_read;
   logic [31:0]       r_gpio;
   logic              r_bus_err;
   logic [31:0]       w_io_rdata;
`ifdef MIO_COUNTER_EN
   logic [31:0]       r_cnt;
   logic [31:0]       r_cnt_snap;
`endif

   mio_addr_decode #(
      .RAM_TOP (RAM_TOP)
   ) u_decode (
      .addr   (bus.addr_bus),
      .region (w_region)
   );

   assign w_req    = bus.CPU_MIO & (bus.MemRead | bus.MemWrite);
   assign w_accept = (r_state == ST_IDLE) & w_req;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // MemWrite wins when both strobes are high.
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_ram_we    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               if (w_region != RGN_RAM) begin
                  w_state_nxt = ST_IO;
               end else if (bus.MemWrite) begin
                  w_state_nxt = ST_RAM_WR;
               end else begin
                  w_state_nxt = ST_RAM_RD;
               end
            end
         end
         ST_RAM_RD: begin
            if (r_wait == c_wait_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_RAM_WR: begin
            w_ram_we    = 1'b1;
            w_state_nxt = ST_DONE;
         end
         ST_IO: begin
            w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            w_ready     = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      w_io_rdata = '0;
      case (r_region)
         RGN_GPIO: w_io_rdata = r_gpio;
         RGN_SW:   w_io_rdata = {16'h0000, sw_in};
`ifdef MIO_COUNTER_EN
         RGN_CNT:  w_io_rdata = r_cnt_snap;
`endif
         default:  w_io_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ram_addr  <= '0;
         r_din       <= '0;
         r_region    <= RGN_NONE;
         r_is_write  <= 1'b0;
         r_wait      <= '0;
         r_data_read <= '0;
         r_gpio      <= '0;
         r_bus_err   <= 1'b0;
`ifdef MIO_COUNTER_EN
         r_cnt_snap  <= '0;
`endif
      end else begin
         if (w_accept) begin
            r_ram_addr <= bus.addr_bus[RAM_AW+1:2];
            r_din      <= bus.Data_write;
            r_region   <= w_region;
            r_is_write <= bus.MemWrite;
            r_wait     <= '0;
`ifdef MIO_COUNTER_EN
            r_cnt_snap <= r_cnt;
`endif
         end
         if (r_state == ST_RAM_RD) begin
            if (r_wait == c_wait_last) begin
               r_data_read <= ram_dout;
            end else begin
               r_wait <= r_wait + 3'd1;
            end
         end
         // Unmapped accesses still complete; reads return zero via the mux.
         if (r_state == ST_IO) begin
            if (r_region == RGN_NONE) begin
               r_bus_err <= 1'b1;
            end
            if (!r_is_write) begin
               r_data_read <= w_io_rdata;
            end else if (r_region == RGN_GPIO) begin
               r_gpio <= r_din;
            end
         end
      end
   end

`ifdef MIO_COUNTER_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if ((r_state == ST_IO) && r_is_write && (r_region == RGN_CNT)) begin
         r_cnt <= r_din;
      end else begin
         r_cnt <= r_cnt + 32'd1;
      end
   end
`endif

   assign bus.Data_read = r_data_read;
   assign bus.MIO_ready = w_ready;
   assign ram_addr      = r_ram_addr;
   assign ram_din       = r_din;
   assign ram_we        = w_ram_we;
   assign gpio_out      = r_gpio;
   assign bus_err       = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mio_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mio_bus_ctrl
// Brief    : Scoreboard bench for mio_bus_ctrl with a behavioural RAM/IO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mio_bus_ctrl;

   localparam int          RAM_AW  = 10;
   localparam int          RAM_LAT = 2;
   localparam logic [31:0] RAM_TOP = 32'h0000_3FFF;
   localparam int          c_words = 1 << RAM_AW;
   localparam int          c_pidx  = (RAM_LAT > 1) ? RAM_LAT - 2 : 0;
`ifdef MIO_COUNTER_EN
   localparam bit          c_cnt_en = 1'b1;
`else
   localparam bit          c_cnt_en = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [RAM_AW-1:0] ram_addr;
   logic [31:0]       ram_din;
   logic              ram_we;
   logic [31:0]       ram_dout;
   logic [15:0]       sw_in;
   logic [31:0]       gpio_out;
   logic              bus_err;

   mio_bus_ctrl_if bus ();

   mio_bus_ctrl #(
      .RAM_AW  (RAM_AW),
      .RAM_LAT (RAM_LAT),
      .RAM_TOP (RAM_TOP)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_we   (ram_we),
      .ram_dout (ram_dout),
      .sw_in    (sw_in),
      .gpio_out (gpio_out),
      .bus_err  (bus_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] fill_pat(input int i);
      return (i == 4) ? 32'hDEAD_BEEF : (32'h1357_9BDF ^ (32'(i) * 32'h9E37_79B9));
   endfunction

   // Environment RAM: data appears RAM_LAT-1 registers after the latched address.
   logic        mem_fill;
   logic [31:0] mem  [0:c_words-1];
   logic [31:0] pipe [0:7];
   always @(posedge clk) begin
      pipe[0] <= mem[ram_addr];
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
      if (mem_fill) begin
         for (int i = 0; i < c_words; i++) mem[i] <= fill_pat(i);
      end else if (ram_we) begin
         mem[ram_addr] <= ram_din;
      end
   end
   assign ram_dout = (RAM_LAT == 1) ? mem[ram_addr] : pipe[c_pidx];

   typedef struct {
      logic [31:0]       data;
      int                cyc;
      logic              err;
      logic [31:0]       gpio;
      logic [RAM_AW-1:0] word;
   } rsp_t;

   typedef struct {
      logic [RAM_AW-1:0] word;
      logic [31:0]       data;
      int                cyc;
   } wr_t;

   rsp_t rsp_q[$];
   wr_t  wr_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   logic [31:0] ref_mem [0:c_words-1];
   logic [31:0] ref_gpio;
   logic        ref_err;
   logic [31:0] last_read;
   logic [31:0] cnt_base;
   int          cnt_base_cyc;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endfunction

   always @(negedge clk) begin
      if (reset === 1'b1 && bus.MIO_ready === 1'b1) begin
         if (rsp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_ready: got 1 expected 0 at cycle %0d", cyc);
         end else begin
            rsp_t e;
            e = rsp_q.pop_front();
            check("Data_read",   bus.Data_read,    e.data);
            check("ready_cycle", 32'(cyc),         32'(e.cyc));
            check("bus_err",     32'(bus_err),     32'(e.err));
            check("gpio_out",    gpio_out,         e.gpio);
            check("ram_addr",    32'(ram_addr),    32'(e.word));
         end
      end
      if (reset === 1'b1 && ram_we === 1'b1) begin
         if (wr_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_ram_we: got 1 expected 0 at cycle %0d", cyc);
         end else begin
            wr_t w;
            w = wr_q.pop_front();
            check("ram_we_addr",  32'(ram_addr), 32'(w.word));
            check("ram_we_data",  ram_din,       w.data);
            check("ram_we_cycle", 32'(cyc),      32'(w.cyc));
         end
      end
   end

   // Called just after a rising edge while the controller is idle.
   task automatic access(input bit wr, input bit both, input logic [31:0] a,
                         input logic [31:0] d, input logic [15:0] sw, input bit drop);
      rsp_t        e;
      wr_t         w;
      logic [31:0] al;
      int          n;
      bit          got;
      n      = cyc;
      al     = a & 32'hFFFF_FFFC;
      sw_in  = sw;
      e.word = RAM_AW'(a >> 2);
      if (al <= RAM_TOP) begin
         if (wr) begin
            w.word = e.word;
            w.data = d;
            w.cyc  = n + 1;
            wr_q.push_back(w);
            ref_mem[e.word] = d;
            e.cyc = n + 2;
         end else begin
            last_read = ref_mem[e.word];
            e.cyc = n + RAM_LAT + 1;
         end
      end else begin
         e.cyc = n + 2;
         if (al == 32'hE000_0000) begin
            if (wr) ref_gpio = d;
            else    last_read = ref_gpio;
         end else if (al == 32'hF000_0000) begin
            if (!wr) last_read = {16'h0000, sw};
         end else if (c_cnt_en && al == 32'hF000_0004) begin
            if (wr) begin
               cnt_base     = d;
               cnt_base_cyc = n + 2;
            end else begin
               last_read = cnt_base + 32'(n - cnt_base_cyc);
            end
         end else begin
            ref_err = 1'b1;
            if (!wr) last_read = 32'h0;
         end
      end
      e.data = last_read;
      e.err  = ref_err;
      e.gpio = ref_gpio;
      rsp_q.push_back(e);

      bus.CPU_MIO    = 1'b1;
      bus.MemWrite   = wr;
      bus.MemRead    = wr ? both : 1'b1;
      bus.addr_bus   = a;
      bus.Data_write = d;
      if (drop) begin
         @(posedge clk);
         #1 bus.CPU_MIO = 1'b0;
      end
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.MIO_ready === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      bus.CPU_MIO  = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      if (!got) begin
         n_cmp++;
         n_err++;
         $display("FAIL ready_timeout: got no MIO_ready expected one for addr %h", a);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (rsp_q.size() != 0 || wr_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d/%0d pending expected 0/0 for addr %h",
                  rsp_q.size(), wr_q.size(), a);
         rsp_q.delete();
         wr_q.delete();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_Data_read"}, bus.Data_read,       32'h0);
      check({tag, "_MIO_ready"}, 32'(bus.MIO_ready),  32'h0);
      check({tag, "_ram_we"},    32'(ram_we),         32'h0);
      check({tag, "_ram_addr"},  32'(ram_addr),       32'h0);
      check({tag, "_ram_din"},   ram_din,             32'h0);
      check({tag, "_gpio_out"},  gpio_out,            32'h0);
      check({tag, "_bus_err"},   32'(bus_err),        32'h0);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      ref_gpio     = 32'h0;
      ref_err      = 1'b0;
      last_read    = 32'h0;
      cnt_base     = 32'h0;
      cnt_base_cyc = cyc;
      @(posedge clk);
      #1;
   endtask

   // Abort a RAM write while ram_we is high; the write must never land.
   task automatic reset_mid_access();
      bus.CPU_MIO    = 1'b1;
      bus.MemWrite   = 1'b1;
      bus.MemRead    = 1'b0;
      bus.addr_bus   = 32'h0000_0040;
      bus.Data_write = 32'h0BAD_0BAD;
      @(posedge clk);
      #1;
      bus.CPU_MIO  = 1'b0;
      bus.MemWrite = 1'b0;
      check("ram_we_before_reset", 32'(ram_we), 32'h1);
      #1 reset = 1'b0;
      #1 check_reset_outputs("midrst");
      release_reset();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset          = 1'b0;
      mem_fill       = 1'b1;
      sw_in          = 16'h0;
      bus.CPU_MIO    = 1'b0;
      bus.MemRead    = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.addr_bus   = 32'h0;
      bus.Data_write = 32'h0;
      for (int i = 0; i < c_words; i++) ref_mem[i] = fill_pat(i);
      repeat (3) @(posedge clk);
      #1 mem_fill = 1'b0;
      check_reset_outputs("init");
      release_reset();

      access(1'b0, 1'b0, 32'h0000_0010, 32'h0,          16'h0,    1'b0);
      access(1'b1, 1'b0, 32'h0000_0020, 32'hA5A5_0001, 16'h0,    1'b0);
      access(1'b0, 1'b0, 32'h0000_0020, 32'h0,          16'h0,    1'b0);
      access(1'b1, 1'b1, 32'hE000_0000, 32'h0000_00FF, 16'h0,    1'b0);
      access(1'b0, 1'b0, 32'hE000_0000, 32'h0,          16'h0,    1'b0);
      access(1'b0, 1'b0, 32'hF000_0000, 32'h0,          16'hBEEF, 1'b0);
      access(1'b1, 1'b0, 32'hF000_0000, 32'h1111_2222, 16'h1234, 1'b0);
      access(1'b0, 1'b0, 32'h8000_0000, 32'h0,          16'h0,    1'b0);
      access(1'b0, 1'b0, 32'h0000_4000, 32'h0,          16'h0,    1'b0);
      access(1'b1, 1'b0, 32'hE000_0000, 32'h0000_1234, 16'h0,    1'b0);
      reset_mid_access();
      access(1'b0, 1'b0, 32'h0000_0040, 32'h0,          16'h0,    1'b0);
      access(1'b0, 1'b0, 32'hF000_0004, 32'h0,          16'h0,    1'b0);
      access(1'b1, 1'b0, 32'hF000_0004, 32'hFFFF_FFFE, 16'h0,    1'b0);
      repeat (3) @(posedge clk);
      #1;
      access(1'b0, 1'b0, 32'hF000_0004, 32'h0,          16'h0,    1'b0);
      access(1'b0, 1'b0, 32'h0000_3FFF, 32'h0,          16'h0,    1'b1);

      for (int t = 0; t < 80; t++) begin
         int          sel;
         logic [31:0] a;
         bit          wr;
         sel = int'($urandom_range(0, 9));
         wr  = 1'($urandom_range(0, 1));
         case (sel)
            0, 1, 2, 3: a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            4:          a = 32'h0000_3FFC + 32'($urandom_range(0, 7));
            5:          a = 32'hE000_0000 | 32'($urandom_range(0, 3));
            6:          a = 32'hF000_0000 | 32'($urandom_range(0, 3));
            7:          a = 32'hF000_0004 | 32'($urandom_range(0, 3));
            8:          a = 32'hE000_0004 + (32'($urandom_range(0, 3)) << 28);
            default:    a = $urandom;
         endcase
         access(wr, 1'($urandom_range(0, 1)), a, $urandom, 16'($urandom),
                ($urandom_range(0, 7) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
